// File: rtl/db_pkg.sv
// Shared definitions for the hash-table engine: op and status encodings,
// value field offsets, entry width helper and the CRC-32 key hash.
package db_pkg;

  localparam int KEY_MAX = 128;
  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2,
    OP_CLEAR  = 2'd3
  } op_e;

  typedef enum logic [3:0] {
    ST_NONE       = 4'd0,
    ST_SUSPECTION = 4'd1,
    ST_ARREST     = 4'd2,
    ST_FILTERED   = 4'd3,
    ST_EXPIRED    = 4'd4
  } status_e;

  typedef enum logic [1:0] {
    CS_IDLE  = 2'd0,
    CS_DRAIN = 2'd1,
    CS_SWEEP = 2'd2,
    CS_DONE  = 2'd3
  } clr_state_e;

  // value layout: [31:28] status, [27:24] flag, [23:8] time, [7:0] reserved
  localparam int VAL_STAT_LO = 28;
  localparam int VAL_STAT_W  = 4;
  localparam int VAL_FLAG_LO = 24;
  localparam int VAL_TIME_LO = 8;
  localparam int VAL_TIME_W  = 16;

  // stored entry is {valid, key, value}
  function automatic int entry_w(input int key_size, input int val_size);
    return 1 + key_size + val_size;
  endfunction

  // MSB-first CRC-32 over the low nbits of key (no reflection, no final xor)
  function automatic logic [31:0] crc32_key(input logic [KEY_MAX-1:0] key, input int nbits);
    logic [31:0]        crc;
    logic [KEY_MAX-1:0] msg;
    logic               fb;
    crc = CRC_INIT;
    msg = key << (KEY_MAX - nbits);
    for (int i = 0; i < KEY_MAX; i++) begin
      if (i < nbits) begin
        fb  = crc[31] ^ msg[KEY_MAX-1-i];
        crc = {crc[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
      end
    end
    return crc;
  endfunction

endpackage

// File: rtl/db_table_ram.sv
// Simple dual-port table RAM: one write port, one registered read port.
// Read-during-write returns old data; the engine forwards around it.
module db_table_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 129
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // write port and registered read port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/db_hash_engine.sv
// Direct-mapped key/value hash engine. 3-stage pipeline:
//   S1 latch request + CRC index, S2 RAM read, S3 compare/respond/write-back.
// CLEAR drains the pipeline then sweeps every entry invalid.
// Optional aging build: define DB_HASH_AGING_EN.
module db_hash_engine
  import db_pkg::*;
#(
  parameter int          KEY_SIZE  = 96,
  parameter int          VAL_SIZE  = 32,
  parameter int          ADDR_W    = 10,
  parameter int          TICK_DIV  = 1024,
  parameter logic [15:0] AGE_LIMIT = 16'd1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_op,
  input  logic [KEY_SIZE-1:0] in_key,
  input  logic [VAL_SIZE-1:0] in_value,
  output logic                out_valid,
  output logic [1:0]          out_op,
  output logic                out_hit,
  output logic                out_evict,
  output logic [VAL_SIZE-1:0] out_value,
  output logic                busy
);

  localparam int ENT_W  = entry_w(KEY_SIZE, VAL_SIZE);
  localparam int STAGES = 3;

  logic                accept;
  logic [STAGES:1]     vld_pipe;
  logic [1:0]          s1_op, s2_op, s3_op;
  logic [KEY_SIZE-1:0] s1_key, s2_key, s3_key;
  logic [VAL_SIZE-1:0] s1_val, s2_val, s3_val;
  logic [ADDR_W-1:0]   s1_idx, s2_idx, s3_idx;
  logic                s2_fwd_vld;
  logic [ENT_W-1:0]    s2_fwd_data, s2_ent, s3_ent, rd_data;

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_idx;
  logic [ENT_W-1:0]    wr_data;

  logic                ent_vld, match, expired, hit, evict, s3_we;
  logic [KEY_SIZE-1:0] ent_key;
  logic [VAL_SIZE-1:0] ent_val, ins_val, resp_val;
  logic [ENT_W-1:0]    s3_wdata;

  clr_state_e          state;
  logic [ADDR_W-1:0]   sweep_idx;
  logic                clr_done;

  assign accept   = in_valid & in_ready;
  assign clr_done = (state == CS_SWEEP) && (&sweep_idx);

`ifdef DB_HASH_AGING_EN
  logic [31:0] tick_cnt;
  logic [15:0] now;
  logic [15:0] age;

  // free-running timestamp, one tick every TICK_DIV cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      now      <= '0;
    end else if (tick_cnt == 32'(TICK_DIV - 1)) begin
      tick_cnt <= '0;
      now      <= now + 16'd1;
    end else begin
      tick_cnt <= tick_cnt + 32'd1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{AGE_LIMIT, TICK_DIV[0]};
`endif

  // pipeline occupancy; CLEAR never enters the pipeline, the FSM owns it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[STAGES-1:1], accept && (in_op != OP_CLEAR)};
  end

  // pipeline payload; S2 also captures a write landing on the same edge as its read
  always_ff @(posedge clk) begin
    s1_op       <= in_op;
    s1_key      <= in_key;
    s1_val      <= in_value;
    s1_idx      <= ADDR_W'(crc32_key(KEY_MAX'(in_key), KEY_SIZE));
    s2_op       <= s1_op;
    s2_key      <= s1_key;
    s2_val      <= s1_val;
    s2_idx      <= s1_idx;
    s2_fwd_vld  <= wr_en && (wr_idx == s1_idx);
    s2_fwd_data <= wr_data;
    s3_op       <= s2_op;
    s3_key      <= s2_key;
    s3_val      <= s2_val;
    s3_idx      <= s2_idx;
    s3_ent      <= s2_ent;
  end

  db_table_ram #(.ADDR_W(ADDR_W), .DATA_W(ENT_W)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .rd_idx  (s1_idx),
    .rd_data (rd_data)
  );

  // S2 entry: newest of (S3 write now, write seen at read edge, RAM data)
  always_comb begin
    s2_ent = rd_data;
    if (s2_fwd_vld) s2_ent = s2_fwd_data;
    if (wr_en && (wr_idx == s2_idx)) s2_ent = wr_data;
  end

  // S3 compare, response value and write-back data
  always_comb begin
    ent_vld = s3_ent[ENT_W-1];
    ent_key = s3_ent[VAL_SIZE +: KEY_SIZE];
    ent_val = s3_ent[VAL_SIZE-1:0];
    match   = ent_vld && (ent_key == s3_key);
    expired = 1'b0;
    ins_val = s3_val;
`ifdef DB_HASH_AGING_EN
    age     = now - ent_val[VAL_TIME_LO +: VAL_TIME_W];
    expired = (s3_op == OP_LOOKUP) && match && (age > AGE_LIMIT);
    ins_val[VAL_TIME_LO +: VAL_TIME_W] = now;
`endif
    hit      = match && !expired;
    evict    = (s3_op == OP_INSERT) && ent_vld && !match;
    s3_we    = 1'b0;
    s3_wdata = {1'b0, ent_key, ent_val};
    case (s3_op)
      OP_LOOKUP: s3_we = expired;
      OP_INSERT: begin
        s3_we    = 1'b1;
        s3_wdata = {1'b1, s3_key, ins_val};
      end
      OP_DELETE: s3_we = match;
      default:   s3_we = 1'b0;
    endcase
    resp_val = hit ? ent_val : '0;
    if (expired) resp_val[VAL_STAT_LO +: VAL_STAT_W] = ST_EXPIRED;
  end

  // single RAM write port: sweep owns it while clearing, else S3
  always_comb begin
    if (state == CS_SWEEP) begin
      wr_en   = 1'b1;
      wr_idx  = sweep_idx;
      wr_data = '0;
    end else begin
      wr_en   = vld_pipe[STAGES] && s3_we;
      wr_idx  = s3_idx;
      wr_data = s3_wdata;
    end
  end

  // CLEAR sequencer: IDLE -> DRAIN -> SWEEP -> DONE -> IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CS_IDLE;
      sweep_idx <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        CS_IDLE: if (accept && (in_op == OP_CLEAR)) begin
          state    <= CS_DRAIN;
          in_ready <= 1'b0;
        end
        CS_DRAIN: if (vld_pipe == '0) begin
          state     <= CS_SWEEP;
          sweep_idx <= '0;
          busy      <= 1'b1;
        end
        CS_SWEEP: begin
          sweep_idx <= sweep_idx + ADDR_W'(1);
          if (&sweep_idx) begin
            state <= CS_DONE;
            busy  <= 1'b0;
          end
        end
        CS_DONE: begin
          state    <= CS_IDLE;
          in_ready <= 1'b1;
        end
        default: state <= CS_IDLE;
      endcase
    end
  end

  // registered response: S3 result or the CLEAR completion strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_op    <= 2'd0;
      out_hit   <= 1'b0;
      out_evict <= 1'b0;
      out_value <= '0;
    end else begin
      out_valid <= vld_pipe[STAGES] | clr_done;
      if (clr_done) begin
        out_op    <= OP_CLEAR;
        out_hit   <= 1'b0;
        out_evict <= 1'b0;
        out_value <= '0;
      end else begin
        out_op    <= s3_op;
        out_hit   <= vld_pipe[STAGES] && hit;
        out_evict <= vld_pipe[STAGES] && evict;
        out_value <= vld_pipe[STAGES] ? resp_val : '0;
      end
    end
  end

endmodule

// File: tb/tb_db_hash_engine.sv
// Bench for db_hash_engine (ADDR_W=4). Reference model is a 16-slot
// direct-mapped table updated atomically at acceptance; responses are
// expected exactly 3 edges later. Aging scenario under DB_HASH_AGING_EN.
module tb_db_hash_engine;

  localparam int TB_AW = 4;
  localparam int SLOTS = 1 << TB_AW;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [95:0] in_key;
  logic [31:0] in_value;
  logic        out_valid;
  logic [1:0]  out_op;
  logic        out_hit;
  logic        out_evict;
  logic [31:0] out_value;
  logic        busy;

  db_hash_engine #(
    .KEY_SIZE(96), .VAL_SIZE(32), .ADDR_W(TB_AW), .TICK_DIV(4), .AGE_LIMIT(16'd2)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_key(in_key), .in_value(in_value),
    .out_valid(out_valid), .out_op(out_op), .out_hit(out_hit),
    .out_evict(out_evict), .out_value(out_value), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [1:0]  op;
    logic        hit;
    logic        evict;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  bit          mv   [SLOTS];
  logic [95:0] mk   [SLOTS];
  logic [31:0] mval [SLOTS];
  int          checks = 0;
  int          errors = 0;
  int          ncyc   = 0;
  int          n_last = -100;

  function automatic int tb_idx(input logic [95:0] k);
    logic [31:0] r;
    r = 32'hFFFF_FFFF;
    for (int i = 95; i >= 0; i--)
      r = (r << 1) ^ (((r[31] ^ k[i]) == 1'b1) ? 32'h04C1_1DB7 : 32'h0);
    return int'(r) & (SLOTS - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, ncyc);
    end
  endtask

  task automatic cyc_step();
    exp_t e;
    @(posedge clk);
    ncyc++;
    @(negedge clk);
    while (exp_q.size() > 0 && exp_q[0].due < ncyc) begin
      e = exp_q.pop_front();
      chk("resp_overdue", 32'(e.due), 32'(ncyc));
    end
    if (exp_q.size() > 0 && exp_q[0].due == ncyc) begin
      e = exp_q.pop_front();
      chk("resp_valid", 32'(out_valid), 32'd1);
      chk("resp_op",    32'(out_op),    32'(e.op));
      chk("resp_hit",   32'(out_hit),   32'(e.hit));
      chk("resp_evict", 32'(out_evict), 32'(e.evict));
      chk("resp_value", out_value,      e.val);
    end else begin
      chk("idle_valid", 32'(out_valid), 32'd0);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) cyc_step();
  endtask

  // present one request for one cycle; model updates if it will be accepted
  task automatic issue(input logic [1:0] op, input logic [95:0] k, input logic [31:0] v);
    exp_t e;
    int   a, ix;
    bit   h;
    in_valid = 1'b1; in_op = op; in_key = k; in_value = v;
    chk("issue_ready", 32'(in_ready), 32'd1);
    if (in_ready) begin
      a = ncyc + 1;
      e.op = op; e.hit = 1'b0; e.evict = 1'b0; e.val = 32'h0;
      if (op == 2'd3) begin
        for (int i = 0; i < SLOTS; i++) mv[i] = 1'b0;
        e.due = ((a + 1 > n_last + 4) ? a + 1 : n_last + 4) + SLOTS;
      end else begin
        ix = tb_idx(k);
        h  = mv[ix] && (mk[ix] == k);
        e.hit = h;
        e.val = h ? mval[ix] : 32'h0;
        if (op == 2'd1) begin
          e.evict  = mv[ix] && !h;
          mv[ix]   = 1'b1;
          mk[ix]   = k;
          mval[ix] = v;
        end else if (op == 2'd2 && h) begin
          mv[ix] = 1'b0;
        end
        e.due  = a + 3;
        n_last = a;
      end
      exp_q.push_back(e);
    end
    cyc_step();
  endtask

  task automatic do_clear();
    int busy_n;
    bit done;
    busy_n = 0;
    done   = 1'b0;
    issue(2'd3, 96'h0, 32'h0);
    in_valid = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      cyc_step();
      chk("clr_ready_low", 32'(in_ready), 32'd0);
      if (busy) busy_n++;
      if (exp_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      chk("clr_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end
    chk("clr_busy_cycles", 32'(busy_n), 32'(SLOTS));
    cyc_step();
    chk("clr_ready_back", 32'(in_ready), 32'd1);
    chk("clr_busy_low", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", ncyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [95:0] k1, k2, k3, k4;
    logic [95:0] pool [8];
    exp_t        e;
    int          r;

    rst = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_key = '0; in_value = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_out_hit",   32'(out_hit),   32'd0);
    chk("rst_out_value", out_value,      32'd0);
    rst = 1'b0;

    // reset in the middle of a sweep returns to idle
    issue(2'd3, 96'h0, 32'h0);
    in_valid = 1'b0;
    repeat (5) cyc_step();
    chk("sweep_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_busy",  32'(busy),      32'd0);
    chk("midrst_ready", 32'(in_ready),  32'd1);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;

    // table contents are unknown until a full CLEAR
    do_clear();

    k1 = 96'h0A000001_0A000002_1F90_0000;
    k2 = k1;
    for (int j = 1; j < 4096; j++) begin
      k2 = k1 ^ 96'(j);
      if (tb_idx(k2) == tb_idx(k1)) break;
    end
    chk("collide_found", 32'(tb_idx(k2)), 32'(tb_idx(k1)));

`ifdef DB_HASH_AGING_EN
    issue(2'd1, k1, 32'h1A00_0000);
    idle(16);
    issue(2'd0, k1, 32'h0);
    e = exp_q.pop_back();
    e.hit = 1'b0;
    e.val = 32'h4000_0000;
    exp_q.push_back(e);
    mv[tb_idx(k1)] = 1'b0;
    issue(2'd0, k1, 32'h0);
    idle(5);
`else
    // insert then lookup, spaced
    issue(2'd1, k1, 32'h1A00_0000);
    idle(3);
    issue(2'd0, k1, 32'h0);
    idle(3);
    // back-to-back insert/lookup needs forwarding
    issue(2'd1, k1, 32'h2B00_1234);
    issue(2'd0, k1, 32'h0);
    // two apart: write lands on the read edge
    issue(2'd1, k1, 32'h3C00_5678);
    idle(1);
    issue(2'd0, k1, 32'h0);
    idle(3);
    // colliding key evicts k1
    issue(2'd1, k2, 32'h1100_0000);
    issue(2'd0, k1, 32'h0);
    issue(2'd0, k2, 32'h0);
    idle(3);
    // delete twice back-to-back
    issue(2'd1, k1, 32'h2200_0000);
    issue(2'd2, k1, 32'h0);
    issue(2'd2, k1, 32'h0);
    idle(3);
    // clear after three inserts; everything then misses
    k3 = 96'hC0A80001_C0A80002_0035_0000;
    k4 = 96'h08080808_01010101_01BB_0000;
    issue(2'd1, k1, 32'h1A00_0000);
    issue(2'd1, k3, 32'h2A00_0000);
    issue(2'd1, k4, 32'h3A00_0000);
    do_clear();
    issue(2'd0, k1, 32'h0);
    issue(2'd0, k3, 32'h0);
    issue(2'd0, k4, 32'h0);
    idle(3);

    // random traffic over a small key pool
    for (int i = 0; i < 8; i++) pool[i] = {$urandom, $urandom, $urandom};
    for (int n = 0; n < 300; n++) begin
      if (n % 100 == 99) do_clear();
      r = $urandom_range(0, 9);
      if (r < 2) idle(1);
      else issue((r < 5) ? 2'd0 : (r < 8) ? 2'd1 : 2'd2,
                 pool[$urandom_range(0, 7)], $urandom);
    end
    idle(6);
`endif

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
